// File: rtl/chaos_prng_core_if.sv
// Load/stream bundle for chaos_prng_core: seed, coupling matrix and gain in,
// float32 state words out. iter_count exists only with PRNG_ITER_COUNT_EN.
interface chaos_prng_core_if #(
    parameter int PRECISION = 32
);
    logic                 tvalid;
    logic [PRECISION-1:0] x0, x1, x2;
    logic [PRECISION-1:0] A00, A01, A02;
    logic [PRECISION-1:0] A10, A11, A12;
    logic [PRECISION-1:0] A20, A21, A22;
    logic [PRECISION-1:0] sigma_in;
    logic                 valid;
    logic [PRECISION-1:0] pseudoRandomNumber1;
    logic [PRECISION-1:0] pseudoRandomNumber2;
    logic [PRECISION-1:0] pseudoRandomNumber3;
`ifdef PRNG_ITER_COUNT_EN
    logic [31:0]          iter_count;
`endif

    modport master (
        output tvalid, x0, x1, x2,
        output A00, A01, A02, A10, A11, A12, A20, A21, A22,
        output sigma_in,
        input  valid,
        input  pseudoRandomNumber1, pseudoRandomNumber2, pseudoRandomNumber3
`ifdef PRNG_ITER_COUNT_EN
        , input iter_count
`endif
    );

    modport slave (
        input  tvalid, x0, x1, x2,
        input  A00, A01, A02, A10, A11, A12, A20, A21, A22,
        input  sigma_in,
        output valid,
        output pseudoRandomNumber1, pseudoRandomNumber2, pseudoRandomNumber3
`ifdef PRNG_ITER_COUNT_EN
        , output iter_count
`endif
    );
endinterface

// File: rtl/chaos_prng_core.sv
// 3-D coupled chaotic-map PRNG, Q8.24 datapath on one shared multiplier.
// Optional iteration counter output enabled by PRNG_ITER_COUNT_EN.
module chaos_prng_core #(
    parameter int PRECISION = 32,
    parameter int SHIFT     = 8
) (
    input logic             clk,
    input logic             reset_n,
    chaos_prng_core_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MAC, SCALE, UPDATE} state_t;

    state_t state, state_nx;

    logic signed [31:0] a_q [0:8];
    logic signed [31:0] x_q [0:2];
    logic signed [31:0] s_q [0:2];
    logic [23:0]        xn_q [0:2];
    logic signed [31:0] sigma_q;
    logic [1:0]         ri, rj;
    logic [3:0]         a_idx;

    logic load_en, mac_en, scale_en, upd_en;
    logic mac_last, scale_last;

    logic signed [31:0] op_a, op_b;
    logic signed [63:0] prod;
    logic [31:0]        prod_q;
    logic [23:0]        frac;
    logic               unused_prod;

    // Out-of-range magnitudes saturate; everything else truncates toward zero
    function automatic logic [31:0] f2q(input logic [31:0] f);
        logic [7:0]  e;
        logic [31:0] mag;
        logic [31:0] q;
        e   = f[30:23];
        mag = {8'd0, 1'b1, f[22:0]};
        if (e >= 8'd126)
            mag = mag << (e - 8'd126);
        else
            mag = mag >> (8'd126 - e);
        q = f[31] ? -mag : mag;
        if (e == 8'd0)
            q = '0;
        else if (e >= 8'd134)
            q = f[31] ? 32'h8000_0001 : 32'h7FFF_FFFF;
        return q;
    endfunction

    function automatic logic [31:0] q2f(input logic [23:0] v);
        logic [31:0] f;
        logic [4:0]  k;
        logic [23:0] sh;
        f = '0;
        k = '0;
        for (int b = 0; b < 24; b++)
            if (v[b]) k = 5'(b);
        sh = v << (5'd23 - k);
        if (v != '0)
            f = {1'b0, 8'd103 + {3'd0, k}, sh[22:0]};
        return f;
    endfunction

    assign a_idx      = {2'b00, ri} * 4'd3 + {2'b00, rj};
    assign mac_last   = (ri == 2'd2) && (rj == 2'd2);
    assign scale_last = (ri == 2'd2);

    always_comb begin
        op_a = sigma_q;
        op_b = s_q[ri];
        if (state == MAC) begin
            op_a = a_q[a_idx];
            op_b = x_q[rj];
        end
    end

    assign prod        = 64'(op_a) * 64'(op_b);
    assign prod_q      = prod[55:24];
    assign frac        = prod[47-SHIFT:24-SHIFT];
    assign unused_prod = ^{prod[63:56], prod[23:0]};

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = IDLE;
            MAC:    if (mac_last) state_nx = SCALE;
            SCALE:  if (scale_last) state_nx = UPDATE;
            UPDATE: state_nx = MAC;
            default: state_nx = IDLE;
        endcase
        // A load wins from any state and restarts the iteration timing
        if (bus.tvalid)
            state_nx = MAC;
    end

    always_comb begin
        load_en  = bus.tvalid;
        mac_en   = 1'b0;
        scale_en = 1'b0;
        upd_en   = 1'b0;
        if (!bus.tvalid) begin
            unique case (1'b1)
                (state == MAC):    mac_en   = 1'b1;
                (state == SCALE):  scale_en = 1'b1;
                (state == UPDATE): upd_en   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int k = 0; k < 9; k++) a_q[k] <= '0;
            for (int k = 0; k < 3; k++) begin
                x_q[k]  <= '0;
                s_q[k]  <= '0;
                xn_q[k] <= '0;
            end
            sigma_q                 <= '0;
            ri                      <= '0;
            rj                      <= '0;
            bus.valid               <= 1'b0;
            bus.pseudoRandomNumber1 <= '0;
            bus.pseudoRandomNumber2 <= '0;
            bus.pseudoRandomNumber3 <= '0;
`ifdef PRNG_ITER_COUNT_EN
            bus.iter_count          <= '0;
`endif
        end else if (load_en) begin
            a_q[0]    <= f2q(bus.A00);
            a_q[1]    <= f2q(bus.A01);
            a_q[2]    <= f2q(bus.A02);
            a_q[3]    <= f2q(bus.A10);
            a_q[4]    <= f2q(bus.A11);
            a_q[5]    <= f2q(bus.A12);
            a_q[6]    <= f2q(bus.A20);
            a_q[7]    <= f2q(bus.A21);
            a_q[8]    <= f2q(bus.A22);
            x_q[0]    <= f2q(bus.x0);
            x_q[1]    <= f2q(bus.x1);
            x_q[2]    <= f2q(bus.x2);
            sigma_q   <= f2q(bus.sigma_in);
            ri        <= '0;
            rj        <= '0;
            bus.valid <= 1'b0;
`ifdef PRNG_ITER_COUNT_EN
            bus.iter_count <= '0;
`endif
        end else begin
            bus.valid <= 1'b0;
            if (mac_en) begin
                s_q[ri] <= ((rj == 2'd0) ? x_q[ri] : s_q[ri]) + prod_q;
                if (rj == 2'd2) begin
                    rj <= '0;
                    ri <= (ri == 2'd2) ? 2'd0 : ri + 2'd1;
                end else begin
                    rj <= rj + 2'd1;
                end
            end
            if (scale_en) begin
                xn_q[ri] <= frac;
                ri       <= (ri == 2'd2) ? 2'd0 : ri + 2'd1;
            end
            if (upd_en) begin
                for (int k = 0; k < 3; k++) x_q[k] <= {8'd0, xn_q[k]};
                bus.pseudoRandomNumber1 <= q2f(xn_q[0]);
                bus.pseudoRandomNumber2 <= q2f(xn_q[1]);
                bus.pseudoRandomNumber3 <= q2f(xn_q[2]);
                bus.valid               <= 1'b1;
`ifdef PRNG_ITER_COUNT_EN
                bus.iter_count          <= bus.iter_count + 32'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_chaos_prng_core.sv
// Directed bench for chaos_prng_core: reset, zero seed, gain, coupling,
// saturation/sign, reseed and mid-run reset with hand-computed words.
module tb_chaos_prng_core;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;
    logic seen;

    chaos_prng_core_if #(.PRECISION(32)) bus ();

    chaos_prng_core #(.PRECISION(32), .SHIFT(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        bus.x0 = 32'hDEADBEEF; bus.x1 = 32'hDEADBEEF; bus.x2 = 32'hDEADBEEF;
        bus.A00 = 32'h12345678; bus.A01 = 32'h12345678;
        bus.A02 = 32'h12345678; bus.A10 = 32'h12345678;
        bus.A11 = 32'h12345678; bus.A12 = 32'h12345678;
        bus.A20 = 32'h12345678; bus.A21 = 32'h12345678;
        bus.A22 = 32'h12345678; bus.sigma_in = 32'hCAFEF00D;
    endtask

    task automatic load(input logic [31:0] v0, v1, v2, sg, a_all, a10);
        bus.x0 = v0; bus.x1 = v1; bus.x2 = v2;
        bus.A00 = a_all; bus.A01 = a_all; bus.A02 = a_all;
        bus.A10 = a10;   bus.A11 = a_all; bus.A12 = a_all;
        bus.A20 = a_all; bus.A21 = a_all; bus.A22 = a_all;
        bus.sigma_in = sg;
        bus.tvalid = 1'b1;
        tick();
        bus.tvalid = 1'b0;
        junk_inputs();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.valid && cyc < 40);
    endtask

    task automatic idle_watch(input int cycles, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.valid) hit = 1'b1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e1, e2, e3);
        check({tag, ".R1"}, bus.pseudoRandomNumber1, e1);
        check({tag, ".R2"}, bus.pseudoRandomNumber2, e2);
        check({tag, ".R3"}, bus.pseudoRandomNumber3, e3);
    endtask

    initial begin
        bus.tvalid = 1'b0;
        junk_inputs();

        // Reset held 10 cycles, then idle with no load
        for (int i = 0; i < 10; i++) tick();
        reset_n = 1'b0;
        idle_watch(30, seen);
        check("rst.valid_seen", {31'd0, seen}, 32'd0);
        check_outs("rst", 32'h0, 32'h0, 32'h0);

        // Zero seed: periodic valids, zero words
        load(32'h0, 32'h0, 32'h0, 32'h4019060E, 32'h3F800000, 32'h3F800000);
        wait_valid(n);
        check("zero.lat1", 32'(n), 32'd13);
        check_outs("zero.v1", 32'h0, 32'h0, 32'h0);
        tick();
        check("zero.fall", {31'd0, bus.valid}, 32'd0);
        wait_valid(n);
        check("zero.lat2", 32'(n + 1), 32'd13);

        // Gain only, then reseed 5 cycles after the second valid
        load(32'h3B000000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0);
        wait_valid(n);
        check("gain.lat1", 32'(n), 32'd13);
        check_outs("gain.v1", 32'h3F000000, 32'h0, 32'h0);
        wait_valid(n);
        check("gain.lat2", 32'(n), 32'd13);
        check_outs("gain.v2", 32'h0, 32'h0, 32'h0);
`ifdef PRNG_ITER_COUNT_EN
        check("gain.iter", bus.iter_count, 32'd2);
`endif
        for (int i = 0; i < 5; i++) tick();
        load(32'h3A800000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h3F800000);
        wait_valid(n);
        check("reseed.lat", 32'(n), 32'd13);
        check_outs("coup.v1", 32'h3E800000, 32'h3E800000, 32'h0);
`ifdef PRNG_ITER_COUNT_EN
        check("reseed.iter", bus.iter_count, 32'd1);
`endif

        // Negative seed, Inf saturation, denormal flush
        load(32'hBB000000, 32'h7F800000, 32'h00400000, 32'h3F800000,
             32'h0, 32'h0);
        wait_valid(n);
        check("mix.lat", 32'(n), 32'd13);
        check_outs("mix.v1", 32'h3F000000, 32'h3F7FFF00, 32'h0);

        // Reset six cycles into the next iteration
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b1;
        #1;
        check("mrst.valid", {31'd0, bus.valid}, 32'd0);
        check_outs("mrst", 32'h0, 32'h0, 32'h0);
`ifdef PRNG_ITER_COUNT_EN
        check("mrst.iter", bus.iter_count, 32'd0);
`endif
        tick(); tick();
        reset_n = 1'b0;
        idle_watch(30, seen);
        check("mrst.valid_seen", {31'd0, seen}, 32'd0);
        load(32'h3B000000, 32'h0, 32'h0, 32'h3F800000, 32'h0, 32'h0);
        wait_valid(n);
        check("mrst.lat", 32'(n), 32'd13);
        check("mrst.R1", bus.pseudoRandomNumber1, 32'h3F000000);
`ifdef PRNG_ITER_COUNT_EN
        check("mrst.iter1", bus.iter_count, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chaos_prng_core.md
Name: chaos_prng_core

Overview:
- Three-dimensional coupled chaotic-map pseudo-random generator for the image-encryption datapath.
- Loads a float32 seed (x0..x2), a 3x3 coupling matrix A and a gain sigma on a tvalid pulse.
- Then iterates freely, presenting each new state as three float32 words with a one-cycle valid strobe.
- Downstream logic consumes the mantissa bits as keystream.

Parameters:
- PRECISION, 32, word width of all value ports. Only 32 (IEEE-754 single) is supported.
- SHIFT, 8, binary expansion exponent of the map (multiply by 2^SHIFT before taking the fractional part).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, ACTIVE-HIGH despite the suffix. While 1, all state is cleared.
- tvalid  in  1  load strobe. Seeds and parameters are sampled on any rising edge where it is 1.
- x0, x1, x2  in  32  float32 seed state.
- A00..A22  in  32 each  float32 coupling matrix Aij (row i, column j).
- sigma_in  in  32  float32 map gain.
- valid  out  1  one-cycle pulse marking new outputs.
- pseudoRandomNumber1/2/3  out  32  float32 of state x0/x1/x2 after the latest iteration.

Behaviour:
- Reset: valid=0, all outputs 0x00000000, internal state/params 0, FSM=IDLE.
- Internal arithmetic: signed fixed-point Q8.24 (32 bit).
- Float-to-Q8.24 conversion (at load only):
  - Zero or denormal gives 0.
  - If unbiased exponent >=7, or on Inf/NaN, saturate to 0x7FFFFFFF or 0x80000001 by sign.
  - Otherwise truncate the magnitude toward zero, then apply the sign.
- Products: 64-bit signed product of two Q8.24 values, arithmetic shift right 24, keep the low 32 bits.
- Sums wrap modulo 2^32.
- One iteration, for each i:
  - c_i = sum_j A_ij*x_j
  - s_i = x_i + c_i
  - p_i = sigma*s_i as the full 64-bit product (Q16.48)
  - x_i' = p_i[47-SHIFT:24-SHIFT], zero-extended. This equals frac(2^SHIFT*sigma*s_i) mod 1, so the state is always in [0,1).
- Q8.24-to-float conversion (state in [0,1)):
  - 0 gives 0x00000000.
  - Otherwise, with leading one at bit k (0..23): sign=0, exponent=127+k-24.
  - Mantissa = bits below k, left-aligned into 23 bits, zero-filled. The conversion is exact, no rounding.
- Hardware uses one shared 32x32 signed multiplier.
- FSM states:
  - IDLE: wait for tvalid.
  - MAC: 9 cycles, products in order i=0..2, j=0..2.
  - SCALE: 3 cycles, sigma*s_0..s_2.
  - UPDATE: 1 cycle. State and outputs are registered and valid is set to 1. Then go to MAC.
- Iteration period is 13 cycles.
- tvalid sampled at edge E0:
  - Params and seed load at E0.
  - valid rises after edge E0+13 and falls after E0+14.
  - Subsequent pulses follow every 13 cycles.
- Generation is free-running after load; there is no backpressure.
- tvalid in any non-IDLE state reseeds: the current iteration is discarded (no valid for it), and timing restarts from that edge.
- Outputs hold their value between valid pulses.
- Input ports are ignored except on tvalid edges.
- reset_n asserted mid-iteration: immediate clear to the reset values, return to IDLE, wait for a new tvalid.

Optional Feature:
- Macro PRNG_ITER_COUNT_EN.
- Defined: adds output iter_count [31:0].
  - Reset and load set it to 0.
  - It increments by 1 on each edge that sets valid, wrapping at 2^32.
  - It updates together with the outputs.
- Undefined: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset: reset_n=1 for 10 cycles, then release with tvalid=0 -> valid stays 0 and all outputs 0x00000000 indefinitely.
- Zero seed: x=0, sigma=0x4019060E, A arbitrary, tvalid pulse at edge E0 -> valid only at E0+13, E0+26, ...; outputs 0x00000000 each time.
- Gain only: x0=0x3B000000 (2^-9), x1=x2=0, A=0, sigma=0x3F800000 -> 1st valid R1=0x3F000000, R2=R3=0; 2nd valid R1=0.
- Coupling: x0=0x3A800000 (2^-10), A10=0x3F800000, other A=0, sigma=1.0 -> 1st valid R1=0x3E800000, R2=0x3E800000, R3=0x00000000.
- Reseed: run the gain-only case, then pulse tvalid with the coupling values 5 cycles after a valid -> no valid for the aborted iteration; next valid 13 cycles after the reseed edge with the coupling results.
- Reset mid-run: assert reset_n 6 cycles into an iteration -> outputs 0 and valid 0 immediately; no valid until a new tvalid + 13 cycles. With PRNG_ITER_COUNT_EN, iter_count=0 and it reads 1 at the first valid after the new tvalid.
